cpu_control_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback, and drives the handshakes to instruction and data memory. It also drives the register file write strobe and writeback-source select, plus the PC and IR/MDR load enables. It sits between the decoder/IR and the datapath (register file, ALU, PC, MDR).

---
 rtl/cpu_control_fsm_pkg.sv | 42 ++++
 rtl/cpu_control_fsm_classifier.sv | 53 +++++
 rtl/cpu_control_fsm.sv | 140 ++++++++++++++
 tb/tb_cpu_control_fsm.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// cpu_control_fsm_pkg : shared writeback, opcode, state and class definitions
// Revision: 1.0
// ============================================================================
package cpu_control_fsm_pkg;

  localparam logic [1:0] REG_WB_ALU_OUT = 2'b00;
  localparam logic [1:0] REG_WB_IMM_DAT = 2'b01;
  localparam logic [1:0] REG_WB_MEM_DAT = 2'b10;
  localparam logic [1:0] REG_WB_PC_NEXT = 2'b11;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef struct packed {
    logic       wb_en;
    logic [1:0] wb_select;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
  } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/cpu_control_fsm_classifier.sv
`default_nettype none
// ============================================================================
// opcode_classifier : maps an RV32I opcode to its legality and control class
// Revision: 1.0
// ============================================================================
module opcode_classifier
  import cpu_control_fsm_pkg::*;
(
  input  logic [6:0]   opcode,
  output logic         legal,
  output instr_class_t cls
);

  always_comb begin
    legal = 1'b0;
    cls   = '0;
    case (opcode)
      OPC_LUI: begin
        legal         = 1'b1;
        cls.wb_en     = 1'b1;
        cls.wb_select = REG_WB_IMM_DAT;
      end
      OPC_AUIPC, OPC_OP_IMM, OPC_OP: begin
        legal         = 1'b1;
        cls.wb_en     = 1'b1;
        cls.wb_select = REG_WB_ALU_OUT;
      end
      OPC_JAL, OPC_JALR: begin
        legal         = 1'b1;
        cls.wb_en     = 1'b1;
        cls.wb_select = REG_WB_PC_NEXT;
        cls.is_jump   = 1'b1;
      end
      OPC_LOAD: begin
        legal         = 1'b1;
        cls.wb_en     = 1'b1;
        cls.wb_select = REG_WB_MEM_DAT;
        cls.is_load   = 1'b1;
      end
      OPC_STORE: begin
        legal        = 1'b1;
        cls.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        legal         = 1'b1;
        cls.is_branch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// cpu_control_fsm : multi-cycle RV32I sequencer with memory-wait watchdog
// Revision: 1.0
// ============================================================================
module cpu_control_fsm
  import cpu_control_fsm_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       reg_we,
  output logic [1:0] wb_select,
  output logic       illegal_instr,
  output logic       bus_error
);

  localparam logic             WD_ON    = (WAIT_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  state_t             state, state_nxt;
  instr_class_t       cls_reg, cls_dec;
  logic               legal_dec;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic               wd_hit;

  opcode_classifier u_classifier (
    .opcode (opcode),
    .legal  (legal_dec),
    .cls    (cls_dec)
  );

  // Current cycle is the WAIT_LIMIT-th without ready unless ready shows up now
  assign wd_hit = WD_ON && (wait_cnt == LIMIT_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      cls_reg  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == S_DECODE) cls_reg <= cls_dec;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = '0;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_we         = 1'b0;
    mdr_we        = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    reg_we        = 1'b0;
    wb_select     = REG_WB_ALU_OUT;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (wd_hit) begin
          bus_error = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (!legal_dec) begin
          illegal_instr = 1'b1;
          pc_we         = 1'b1;
          state_nxt     = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls_reg.is_branch) begin
          pc_we     = 1'b1;
          pc_sel    = branch_taken;
          state_nxt = S_FETCH;
        end else if (cls_reg.is_load || cls_reg.is_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls_reg.is_store;
        if (dmem_ready) begin
          if (cls_reg.is_store) begin
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            mdr_we    = 1'b1;
            state_nxt = S_WB;
          end
        end else if (wd_hit) begin
          bus_error = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_we    = cls_reg.wb_en;
        wb_select = cls_reg.wb_select;
        pc_we     = 1'b1;
        pc_sel    = cls_reg.is_jump;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_RESET;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// tb_cpu_control_fsm : directed cycle-by-cycle output checks, WAIT_LIMIT = 4
// Revision: 1.0
// ============================================================================
module tb_cpu_control_fsm;

  // Output vector: {imem_req,dmem_req,dmem_we,ir_we | mdr_we,pc_we,pc_sel,reg_we | wb_select,illegal,bus_error}
  localparam logic [11:0] O_IDLE   = 12'b0000_0000_0000;
  localparam logic [11:0] O_FWAIT  = 12'b1000_0000_0000;
  localparam logic [11:0] O_FRDY   = 12'b1001_0000_0000;
  localparam logic [11:0] O_FABORT = 12'b1000_0000_0001;
  localparam logic [11:0] O_WB_ALU = 12'b0000_0101_0000;
  localparam logic [11:0] O_WB_IMM = 12'b0000_0101_0100;
  localparam logic [11:0] O_WB_MEM = 12'b0000_0101_1000;
  localparam logic [11:0] O_WB_PC  = 12'b0000_0111_1100;
  localparam logic [11:0] O_BR_T   = 12'b0000_0110_0000;
  localparam logic [11:0] O_BR_NT  = 12'b0000_0100_0000;
  localparam logic [11:0] O_LD_W   = 12'b0100_0000_0000;
  localparam logic [11:0] O_LD_RDY = 12'b0100_1000_0000;
  localparam logic [11:0] O_ST_W   = 12'b0110_0000_0000;
  localparam logic [11:0] O_ST_RDY = 12'b0110_0100_0000;
  localparam logic [11:0] O_ST_ABT = 12'b0110_0100_0001;
  localparam logic [11:0] O_ILL    = 12'b0000_0100_0010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_taken, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we, ir_we, mdr_we, pc_we, pc_sel, reg_we;
  logic [1:0] wb_select;
  logic       illegal_instr, bus_error;
  logic [11:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_control_fsm #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .imem_req      (imem_req),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .ir_we         (ir_we),
    .mdr_we        (mdr_we),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .reg_we        (reg_we),
    .wb_select     (wb_select),
    .illegal_instr (illegal_instr),
    .bus_error     (bus_error)
  );

  always #5 clk = ~clk;

  assign obs = {imem_req, dmem_req, dmem_we, ir_we, mdr_we, pc_we, pc_sel, reg_we,
                wb_select, illegal_instr, bus_error};

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Check outputs at the falling edge, then advance to just after the next rising edge
  task automatic step(input string tag, input logic [11:0] exp);
    @(negedge clk);
    check_eq(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag, input logic [6:0] opc);
    opcode     = opc;
    imem_ready = 1'b1;
    step({tag, "_fetch"}, O_FRDY);
    imem_ready = 1'b0;
    step({tag, "_decode"}, O_IDLE);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'd0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (3) step("reset_hold", O_IDLE);
    rst_n = 1'b1;
    step("s_reset", O_IDLE);

    // OP with immediate readies; imem_ready left high through DECODE is stray
    opcode = 7'b0110011; imem_ready = 1'b1;
    step("op_fetch", O_FRDY);
    step("op_decode", O_IDLE);
    imem_ready = 1'b0;
    step("op_exec", O_IDLE);
    step("op_wb", O_WB_ALU);

    // LOAD, dmem_ready after 3 wait cycles (ready lands on the limit cycle)
    fetch_decode("ld", 7'b0000011);
    dmem_ready = 1'b1;
    step("ld_exec_stray_ready", O_IDLE);
    dmem_ready = 1'b0;
    repeat (3) step("ld_mem_wait", O_LD_W);
    dmem_ready = 1'b1;
    step("ld_mem_ready", O_LD_RDY);
    dmem_ready = 1'b0;
    step("ld_wb", O_WB_MEM);

    fetch_decode("br_t", 7'b1100011);
    branch_taken = 1'b1;
    step("br_taken_exec", O_BR_T);
    branch_taken = 1'b0;
    fetch_decode("br_nt", 7'b1100011);
    step("br_not_taken_exec", O_BR_NT);

    fetch_decode("st", 7'b0100011);
    step("st_exec", O_IDLE);
    dmem_ready = 1'b1;
    step("st_mem_ready", O_ST_RDY);
    dmem_ready = 1'b0;

    fetch_decode("jal", 7'b1101111);
    step("jal_exec", O_IDLE);
    step("jal_wb", O_WB_PC);

    fetch_decode("lui", 7'b0110111);
    step("lui_exec", O_IDLE);
    step("lui_wb", O_WB_IMM);

    opcode = 7'b1110011; imem_ready = 1'b1;
    step("ill_fetch", O_FRDY);
    imem_ready = 1'b0;
    step("ill_decode", O_ILL);

    // Fetch watchdog: abort on 4th idle cycle, then retry with cleared counter
    repeat (3) step("fetch_wait", O_FWAIT);
    step("fetch_abort", O_FABORT);
    repeat (3) step("fetch_retry_wait", O_FWAIT);
    opcode = 7'b0100011; imem_ready = 1'b1;
    step("fetch_ready_at_limit", O_FRDY);
    imem_ready = 1'b0;
    step("st2_decode", O_IDLE);
    step("st2_exec", O_IDLE);
    repeat (3) step("st2_mem_wait", O_ST_W);
    step("st2_mem_abort", O_ST_ABT);

    // Reset in the middle of a data request
    fetch_decode("ld2", 7'b0000011);
    step("ld2_exec", O_IDLE);
    step("ld2_mem_wait", O_LD_W);
    #2 rst_n = 1'b0;
    #1 check_eq("reset_mid_mem", obs, O_IDLE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("s_reset_after_abort", O_IDLE);
    step("fetch_after_reset", O_FWAIT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
